// File: rtl/ccm_matrix_pipe.sv
// rtl/ccm_matrix_pipe.sv - 3x3 colour matrix with frame-boundary coefficient commit, offset and saturation.
// Define CCM_ROUND_EN for round-half-up before the fractional shift; default is floor.
module ccm_matrix_pipe #(
   parameter int DATA_W     = 18,
   parameter int COEF_W     = 18,
   parameter int FRAC_BITS  = 10,
   parameter int OUT_W      = 18,
   parameter int FRAME_SIZE = 76800
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_W-1:0]     iX,
   input  logic [DATA_W-1:0]     iY,
   input  logic [DATA_W-1:0]     iZ,
   input  logic                  iValid,
   input  logic [9*COEF_W-1:0]   coef_in,
   input  logic [3*OUT_W-1:0]    offset_in,
   input  logic                  coef_load,
   output logic [OUT_W-1:0]      oA,
   output logic [OUT_W-1:0]      oB,
   output logic [OUT_W-1:0]      oC,
   output logic                  oValid,
   output logic                  oFrameEnd,
   output logic                  oDone
);

   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ACC_W  = DATA_W + COEF_W + 2;
   localparam int SUM_W  = ACC_W + 2;
   localparam int CNT_W  = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_SIZE - 1);

`ifdef CCM_ROUND_EN
   localparam logic signed [ACC_W:0] RND = ((ACC_W+1)'(1) << FRAC_BITS) >> 1;
`else
   localparam logic signed [ACC_W:0] RND = '0;
`endif

   localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic [9*COEF_W-1:0] ident_coef;
   logic [9*COEF_W-1:0] act_coef;
   logic [9*COEF_W-1:0] pend_coef;
   logic [9*COEF_W-1:0] sel_coef;
   logic [3*OUT_W-1:0]  act_off;
   logic [3*OUT_W-1:0]  pend_off;
   logic [3*OUT_W-1:0]  sel_off;
   logic                pend;
   logic                at_start;
   logic                commit;
   logic [CNT_W-1:0]    in_cnt;
   logic [CNT_W-1:0]    out_cnt;
   logic                done_r;

   logic                       v1, v2, v3;
   logic signed [DATA_W-1:0]   in_vec [3];
   logic signed [PROD_W-1:0]   s1_prod [9];
   logic [3*OUT_W-1:0]         s1_off;
   logic signed [ACC_W-1:0]    s2_acc [3];
   logic [3*OUT_W-1:0]         s2_off;
   logic signed [ACC_W:0]      rnd [3];
   logic signed [ACC_W:0]      shifted [3];
   logic signed [SUM_W-1:0]    sum [3];
   logic [OUT_W-1:0]           sat [3];

   always_comb begin
      ident_coef = '0;
      for (int k = 0; k < 3; k++) begin
         ident_coef[(8-4*k)*COEF_W +: COEF_W] = COEF_W'(1) << FRAC_BITS;
      end
   end

   // The first pixel of a frame already sees a pending set, so no bubble is needed at the boundary.
   assign at_start = (in_cnt == '0);
   assign commit   = iValid && pend && at_start;
   assign sel_coef = (pend && at_start) ? pend_coef : act_coef;
   assign sel_off  = (pend && at_start) ? pend_off  : act_off;

   always_ff @(posedge clk) begin
      if (reset) begin
         act_coef <= ident_coef;
         act_off  <= '0;
         pend     <= 1'b0;
         in_cnt   <= '0;
      end else begin
         if (commit) begin
            act_coef <= pend_coef;
            act_off  <= pend_off;
         end
         if (coef_load) begin
            pend_coef <= coef_in;
            pend_off  <= offset_in;
            pend      <= 1'b1;
         end else if (commit) begin
            pend <= 1'b0;
         end
         if (iValid) begin
            in_cnt <= (in_cnt == LAST_PIX) ? '0 : in_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else begin
         v1 <= iValid;
         v2 <= v1;
         v3 <= v2;
      end
   end

   assign in_vec[0] = $signed(iX);
   assign in_vec[1] = $signed(iY);
   assign in_vec[2] = $signed(iZ);

   always_ff @(posedge clk) begin
      for (int k = 0; k < 9; k++) begin
         s1_prod[k] <= PROD_W'(in_vec[k % 3]) * PROD_W'($signed(sel_coef[(8-k)*COEF_W +: COEF_W]));
      end
      s1_off <= sel_off;
   end

   always_ff @(posedge clk) begin
      for (int r = 0; r < 3; r++) begin
         s2_acc[r] <= ACC_W'(s1_prod[3*r]) + ACC_W'(s1_prod[3*r+1]) + ACC_W'(s1_prod[3*r+2]);
      end
      s2_off <= s1_off;
   end

   // One extra bit keeps the rounding add from overflowing before the shift.
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         rnd[r]     = {s2_acc[r][ACC_W-1], s2_acc[r]} + RND;
         shifted[r] = rnd[r] >>> FRAC_BITS;
         sum[r]     = SUM_W'(shifted[r]) + SUM_W'($signed(s2_off[(2-r)*OUT_W +: OUT_W]));
         if (sum[r] > SAT_MAX) begin
            sat[r] = SAT_MAX[OUT_W-1:0];
         end else if (sum[r] < SAT_MIN) begin
            sat[r] = SAT_MIN[OUT_W-1:0];
         end else begin
            sat[r] = sum[r][OUT_W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      oA <= sat[0];
      oB <= sat[1];
      oC <= sat[2];
   end

   assign oValid    = v3;
   assign oFrameEnd = v3 && (out_cnt == LAST_PIX);
   assign oDone     = done_r || oFrameEnd;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_cnt <= '0;
         done_r  <= 1'b0;
      end else if (v3) begin
         out_cnt <= (out_cnt == LAST_PIX) ? '0 : out_cnt + 1'b1;
         if (out_cnt == LAST_PIX) begin
            done_r <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ccm_matrix_pipe.sv
// tb/tb_ccm_matrix_pipe.sv - scoreboard bench for ccm_matrix_pipe with an arithmetic reference model.
// Honours CCM_ROUND_EN in the reference model the same way as the design.
module tb_ccm_matrix_pipe;

   localparam int DW = 18;
   localparam int CW = 18;
   localparam int OW = 18;
   localparam int FB = 10;
   localparam int FS = 4;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [DW-1:0]   iX = '0, iY = '0, iZ = '0;
   logic            iValid = 1'b0;
   logic [9*CW-1:0] coef_in = '0;
   logic [3*OW-1:0] offset_in = '0;
   logic            coef_load = 1'b0;
   logic [OW-1:0]   oA, oB, oC;
   logic            oValid, oFrameEnd, oDone;

   ccm_matrix_pipe #(
      .DATA_W(DW), .COEF_W(CW), .FRAC_BITS(FB), .OUT_W(OW), .FRAME_SIZE(FS)
   ) dut (
      .clk(clk), .reset(reset), .iX(iX), .iY(iY), .iZ(iZ), .iValid(iValid),
      .coef_in(coef_in), .offset_in(offset_in), .coef_load(coef_load),
      .oA(oA), .oB(oB), .oC(oC), .oValid(oValid), .oFrameEnd(oFrameEnd), .oDone(oDone)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint a, b, c;
      bit     fe, done;
      int     due;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   int  m_act[9], m_pc[9], m_aoff[3], m_poff[3];
   bit  m_pend;
   int  m_incnt;
   bit  m_done;
   int  ld_c[9];
   int  ld_o[3];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint got, input longint want);
      tests++;
      if (got != want) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, got, want);
      end
   endtask

   function automatic longint clamp(input longint v);
      if (v > 131071) return 131071;
      if (v < -131072) return -131072;
      return v;
   endfunction

   task automatic model_reset();
      m_act  = '{1024, 0, 0, 0, 1024, 0, 0, 0, 1024};
      m_aoff = '{0, 0, 0};
      m_pend = 0;
      m_incnt = 0;
      m_done = 0;
   endtask

   task automatic step(input bit v, input int x, input int y, input int z, input bit ld);
      int     uc[9];
      int     uo[3];
      longint in3[3];
      longint res[3];
      longint acc;
      exp_t   e;
      iValid = v;
      iX = DW'(x);
      iY = DW'(y);
      iZ = DW'(z);
      coef_load = ld;
      for (int k = 0; k < 9; k++) coef_in[(8-k)*CW +: CW] = CW'(ld_c[k]);
      for (int r = 0; r < 3; r++) offset_in[(2-r)*OW +: OW] = OW'(ld_o[r]);
      if (v) begin
         uc = (m_pend && m_incnt == 0) ? m_pc : m_act;
         uo = (m_pend && m_incnt == 0) ? m_poff : m_aoff;
         in3 = '{longint'(x), longint'(y), longint'(z)};
         for (int r = 0; r < 3; r++) begin
            acc = 0;
            for (int c = 0; c < 3; c++) acc += longint'(uc[r*3+c]) * in3[c];
`ifdef CCM_ROUND_EN
            acc += 512;
`endif
            res[r] = clamp((acc >>> FB) + longint'(uo[r]));
         end
         e.a = res[0];
         e.b = res[1];
         e.c = res[2];
         e.fe = (m_incnt == FS - 1);
         m_done = m_done | e.fe;
         e.done = m_done;
         e.due = cyc + 3;
         q.push_back(e);
         if (m_pend && m_incnt == 0) begin
            m_act = m_pc;
            m_aoff = m_poff;
            m_pend = 0;
         end
         m_incnt = (m_incnt == FS - 1) ? 0 : m_incnt + 1;
      end
      if (ld) begin
         m_pc = ld_c;
         m_poff = ld_o;
         m_pend = 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rst_cycles(input int n);
      reset = 1'b1;
      iValid = 1'b0;
      coef_load = 1'b1;
      while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
      model_reset();
      repeat (n) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      coef_load = 1'b0;
   endtask

   function automatic int rnd18();
      return int'($urandom_range(0, 262143)) - 131072;
   endfunction

   task automatic fill_frame();
      while (m_incnt != 0) step(1, rnd18(), rnd18(), rnd18(), 0);
   endtask

   task automatic set_load(input int d0, input int d1, input int d2, input int oa);
      ld_c = '{d0, 0, 0, 0, d1, 0, 0, 0, d2};
      ld_o = '{oa, 0, 0};
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (oValid) begin
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_valid at cycle %0d: got oValid 1 expected 0", cyc);
         end else begin
            e = q.pop_front();
            chk("latency", cyc, e.due);
            chk("oA", $signed(oA), e.a);
            chk("oB", $signed(oB), e.b);
            chk("oC", $signed(oC), e.c);
            chk("oFrameEnd", oFrameEnd, e.fe);
            chk("oDone", oDone, e.done);
         end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
         tests++;
         fails++;
         $display("FAIL missing_output at cycle %0d: got oValid 0 expected 1", cyc);
         void'(q.pop_front());
      end
   end

   initial begin
      set_load(0, 0, 0, 0);
      model_reset();
      m_pc = ld_c;
      m_poff = ld_o;
      @(posedge clk);
      #1;
      rst_cycles(2);
      chk("reset_oValid", oValid, 0);
      chk("reset_oFrameEnd", oFrameEnd, 0);
      chk("reset_oDone", oDone, 0);

      step(1, 100, -50, 7, 0);
      repeat (4) step(0, 0, 0, 0, 0);
      fill_frame();

      set_load(4096, 1024, 1024, 0);
      step(0, 0, 0, 0, 1);
      step(1, 100000, 1, 2, 0);
      step(1, -100000, 3, 4, 0);
      fill_frame();

      set_load(512, 1024, 1024, 0);
      step(0, 0, 0, 0, 1);
      step(1, 3, 0, 0, 0);
      step(1, -3, 0, 0, 0);
      fill_frame();

      set_load(1024, 1024, 1024, 20);
      step(0, 0, 0, 0, 1);
      step(1, 5, 6, 7, 0);
      fill_frame();
      set_load(1024, 1024, 1024, -131072);
      step(0, 0, 0, 0, 1);
      step(1, -1, 0, 0, 0);
      fill_frame();

      // Continuous frame with a load at pixel 1, then a load coinciding with the commit pixel.
      set_load(1024, 1024, 1024, 0);
      step(0, 0, 0, 0, 1);
      step(1, 11, 22, 33, 0);
      set_load(2048, 2048, 2048, 0);
      step(1, 11, 22, 33, 1);
      step(1, 11, 22, 33, 0);
      step(1, 11, 22, 33, 0);
      set_load(3072, 1024, -1024, 5);
      step(1, 11, 22, 33, 1);
      for (int i = 0; i < 7; i++) step(1, rnd18(), rnd18(), rnd18(), 0);

      set_load(3072, 3072, 3072, 0);
      step(1, 40, 41, 42, 1);
      step(1, 43, 44, 45, 0);
      rst_cycles(1);
      for (int i = 0; i < 4; i++) step(1, 200 + i, -i, i, 0);
      repeat (5) step(0, 0, 0, 0, 0);

      for (int i = 0; i < 400; i++) begin
         int r;
         bit ld;
         r = int'($urandom_range(0, 99));
         if (r < 2) begin
            rst_cycles(1);
         end else begin
            ld = ($urandom_range(0, 9) == 0);
            if (ld) begin
               for (int k = 0; k < 9; k++) ld_c[k] = int'($urandom_range(0, 8192)) - 4096;
               for (int k = 0; k < 3; k++) ld_o[k] = rnd18();
            end
            step(r < 80, rnd18(), rnd18(), rnd18(), ld);
         end
      end

      iValid = 1'b0;
      coef_load = 1'b0;
      for (int i = 0; i < 20 && q.size() > 0; i++) begin
         @(posedge clk);
         #1;
      end
      if (q.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: got %0d outstanding expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
